// File: rtl/usrt_pkg.sv
// Shared USRT definitions: Rx frame layout, bit positions and the receive FSM state type.
package usrt_pkg;

    localparam int FRAME_W   = 11;
    localparam int START_BIT = 0;
    localparam int DATA_LSB  = 1;
    localparam int DATA_MSB  = 8;
    localparam int PAR_BIT   = 9;
    localparam int STOP_BIT  = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CHECK   = 2'd2
    } rx_state_t;

    function automatic logic [7:0] frame_data(input logic [FRAME_W-1:0] frame);
        return frame[DATA_MSB:DATA_LSB];
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Small byte FIFO for received data: push/pop ports, full/empty flags and occupancy level.
module rx_fifo #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int LVL_W  = AW + 1
) (
    input  logic              i_Pclk,
    input  logic              i_Rst_n,
    input  logic              i_Push,
    input  logic [DATA_W-1:0] i_Data,
    input  logic              i_Pop,
    output logic [DATA_W-1:0] o_Data,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [LVL_W-1:0]  o_Level
);

    logic [DATA_W-1:0] r_Mem [DEPTH];
    logic [AW-1:0]     r_WrPtr;
    logic [AW-1:0]     r_RdPtr;
    logic [LVL_W-1:0]  r_Level;
    logic              w_Push;
    logic              w_Pop;

    // A push into a full FIFO is allowed only when a pop frees a slot on the same edge.
    assign w_Pop  = i_Pop & ~o_Empty;
    assign w_Push = i_Push & (~o_Full | w_Pop);

    always_ff @(posedge i_Pclk) begin
        if (w_Push) begin
            r_Mem[r_WrPtr] <= i_Data;
        end
    end

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_WrPtr <= '0;
            r_RdPtr <= '0;
            r_Level <= '0;
        end else begin
            if (w_Push) begin
                r_WrPtr <= r_WrPtr + AW'(1);
            end
            if (w_Pop) begin
                r_RdPtr <= r_RdPtr + AW'(1);
            end
            case ({w_Push, w_Pop})
                2'b10:   r_Level <= r_Level + LVL_W'(1);
                2'b01:   r_Level <= r_Level - LVL_W'(1);
                default: r_Level <= r_Level;
            endcase
        end
    end

    assign o_Full  = (r_Level == LVL_W'(DEPTH));
    assign o_Empty = (r_Level == '0);
    assign o_Level = r_Level;
    assign o_Data  = o_Empty ? '0 : r_Mem[r_RdPtr];

endmodule

// File: rtl/rx_frame_ctrl.sv
// USRT receive controller: validates 11-bit frames, queues good bytes, tracks errors.
// Optional parity checking is enabled by defining RX_PARITY_EN.
module rx_frame_ctrl
    import usrt_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    parameter  bit PARITY_ODD = 1'b0,
    parameter  int CNT_W      = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               i_Pclk,
    input  logic               i_Rst_n,
    input  logic               i_Rx_En,
    input  logic               i_Frame_Done,
    input  logic [FRAME_W-1:0] i_Frame,
    output logic [7:0]         o_Data,
    output logic               o_Valid,
    input  logic               i_Ready,
    output logic               o_Frame_Err,
    output logic               o_Parity_Err,
    output logic               o_Overrun,
    input  logic               i_Clr_Err,
    output logic [CNT_W-1:0]   o_Err_Cnt,
    output logic [LVL_W-1:0]   o_Level
);

    rx_state_t          r_State;
    rx_state_t          w_NextState;
    logic [FRAME_W-1:0] r_Frame;
    logic               r_FrameErr;
    logic               r_Overrun;
    logic [CNT_W-1:0]   r_ErrCnt;

    logic               w_Latch;
    logic               w_Eval;
    logic               w_FrameBad;
    logic               w_ParBad;
    logic               w_Good;
    logic               w_Full;
    logic               w_Empty;
    logic               w_Pop;
    logic               w_Push;
    logic               w_Drop;
    logic               w_CntInc;

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State <= IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    // Frames arriving outside IDLE are ignored; a started sequence always runs to completion.
    always_comb begin
        w_NextState = r_State;
        w_Latch     = 1'b0;
        w_Eval      = 1'b0;
        case (r_State)
            IDLE: begin
                if (i_Frame_Done && i_Rx_En) begin
                    w_NextState = CAPTURE;
                    w_Latch     = 1'b1;
                end
            end
            CAPTURE: begin
                w_NextState = CHECK;
            end
            CHECK: begin
                w_NextState = IDLE;
                w_Eval      = 1'b1;
            end
            default: begin
                w_NextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Frame <= '0;
        end else if (w_Latch) begin
            r_Frame <= i_Frame;
        end
    end

    assign w_FrameBad = w_Eval & (r_Frame[START_BIT] | ~r_Frame[STOP_BIT]);

`ifdef RX_PARITY_EN
    logic r_ParityErr;

    assign w_ParBad = w_Eval & ((^r_Frame[PAR_BIT:DATA_LSB]) != PARITY_ODD);

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_ParityErr <= 1'b0;
        end else if (i_Clr_Err) begin
            r_ParityErr <= 1'b0;
        end else if (w_ParBad) begin
            r_ParityErr <= 1'b1;
        end
    end

    assign o_Parity_Err = r_ParityErr;
`else
    logic w_unused_par;

    assign w_unused_par = r_Frame[PAR_BIT] ^ PARITY_ODD;
    assign w_ParBad     = 1'b0;
    assign o_Parity_Err = 1'b0;
`endif

    // A good frame meeting a full FIFO still goes in if the consumer pops on the same edge.
    assign w_Good   = w_Eval & ~w_FrameBad & ~w_ParBad;
    assign w_Pop    = o_Valid & i_Ready;
    assign w_Push   = w_Good & (~w_Full | w_Pop);
    assign w_Drop   = w_Good & w_Full & ~w_Pop;
    assign w_CntInc = w_FrameBad | w_ParBad | w_Drop;

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_FrameErr <= 1'b0;
            r_Overrun  <= 1'b0;
        end else if (i_Clr_Err) begin
            r_FrameErr <= 1'b0;
            r_Overrun  <= 1'b0;
        end else begin
            if (w_FrameBad) begin
                r_FrameErr <= 1'b1;
            end
            if (w_Drop) begin
                r_Overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_ErrCnt <= '0;
        end else if (w_CntInc && (r_ErrCnt != '1)) begin
            r_ErrCnt <= r_ErrCnt + CNT_W'(1);
        end
    end

    rx_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_rx_fifo (
        .i_Pclk  (i_Pclk),
        .i_Rst_n (i_Rst_n),
        .i_Push  (w_Push),
        .i_Data  (frame_data(r_Frame)),
        .i_Pop   (i_Ready),
        .o_Data  (o_Data),
        .o_Full  (w_Full),
        .o_Empty (w_Empty),
        .o_Level (o_Level)
    );

    assign o_Valid     = ~w_Empty;
    assign o_Frame_Err = r_FrameErr;
    assign o_Overrun   = r_Overrun;
    assign o_Err_Cnt   = r_ErrCnt;

endmodule
